// File: rtl/reduce_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : reduce_tree_pipe
// Summary  : Pipelined WIDTH-bit OR/AND/XOR/NOR reduction through a tree of
//            3-input gates, one register stage per level, valid/ready on both
//            sides. Optional macro REDUCE_STATS_EN adds a saturating hit_count.
// Revision : 1.0 - initial release
// ============================================================================
module reduce_tree_pipe #(
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic [1:0]       out_mode
`ifdef REDUCE_STATS_EN
    ,
    output logic [15:0]      hit_count
`endif
);

    function automatic int calc_levels(input int n);
        int l;
        int p;
        l = 0;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            if (p < n) begin
                p = p * 3;
                l = l + 1;
            end
        end
        return l;
    endfunction

    // Width of the vector produced by level k.
    function automatic int lvl_w(input int k);
        int w;
        w = WIDTH;
        for (int i = 0; i <= k; i++) begin
            w = (w + 2) / 3;
        end
        return w;
    endfunction

    // Every level's registered vector lives in one flat bus at this offset.
    function automatic int lvl_off(input int k);
        int s;
        s = 0;
        for (int i = 0; i < k; i++) begin
            s = s + lvl_w(i);
        end
        return s;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH);
    localparam int TOT    = lvl_off(LEVELS);

    localparam logic [1:0] C_MODE_AND = 2'b01;
    localparam logic [1:0] C_MODE_XOR = 2'b10;
    localparam logic [1:0] C_MODE_NOR = 2'b11;

    logic [LEVELS-1:0] r_valid;
    logic [1:0]        r_mode [LEVELS];
    logic [TOT-1:0]    r_flat;

    logic [LEVELS-1:0] w_load;
    logic [LEVELS-1:0] w_pv;
    logic [1:0]        w_pm [LEVELS];
    logic [TOT-1:0]    w_nxt;
    logic [TOT-1:0]    w_en;

    always_comb begin
        w_pv[0] = in_valid;
        w_pm[0] = in_mode;
        for (int k = 1; k < LEVELS; k++) begin
            w_pv[k] = r_valid[k-1];
            w_pm[k] = r_mode[k-1];
        end
    end

    // A stage loads if it or any stage downstream of it has room this cycle.
    always_comb begin : p_ready
        logic v_acc;
        v_acc  = out_ready;
        w_load = '0;
        for (int k = LEVELS - 1; k >= 0; k--) begin
            v_acc     = v_acc | ~r_valid[k];
            w_load[k] = v_acc;
        end
    end

    assign in_ready = w_load[0] & ~rst;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int IN_W  = (k == 0) ? WIDTH : lvl_w(k - 1);
        localparam int OUT_W = lvl_w(k);
        localparam int OFF   = lvl_off(k);

        logic [IN_W-1:0] w_in;

        if (k == 0) begin : g_src_in
            assign w_in = in_data;
        end else begin : g_src_reg
            assign w_in = r_flat[lvl_off(k - 1) +: IN_W];
        end

        assign w_en[OFF +: OUT_W] = {OUT_W{w_load[k] & w_pv[k]}};

        for (genvar g = 0; g < OUT_W; g++) begin : g_grp
            logic [2:0] w_trip;
            logic       w_gate;

            for (genvar j = 0; j < 3; j++) begin : g_tap
                if (3 * g + j < IN_W) begin : g_bit
                    assign w_trip[j] = w_in[3*g+j];
                end else begin : g_pad
                    assign w_trip[j] = (w_pm[k] == C_MODE_AND);
                end
            end

            // NOR travels through the tree as OR.
            always_comb begin
                case (w_pm[k])
                    C_MODE_AND: w_gate = &w_trip;
                    C_MODE_XOR: w_gate = ^w_trip;
                    default:    w_gate = |w_trip;
                endcase
            end

            if (k == LEVELS - 1) begin : g_inv
                assign w_nxt[OFF+g] = w_gate ^ (w_pm[k] == C_MODE_NOR);
            end else begin : g_pass
                assign w_nxt[OFF+g] = w_gate;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_flat  <= '0;
            for (int k = 0; k < LEVELS; k++) begin
                r_mode[k] <= 2'b00;
            end
        end else begin
            r_flat <= (r_flat & ~w_en) | (w_nxt & w_en);
            for (int k = 0; k < LEVELS; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= w_pv[k];
                    if (w_pv[k]) begin
                        r_mode[k] <= w_pm[k];
                    end
                end
            end
        end
    end

    assign out_valid = r_valid[LEVELS-1];
    assign out_y     = r_flat[TOT-1];
    assign out_mode  = r_mode[LEVELS-1];

`ifdef REDUCE_STATS_EN
    logic [15:0] r_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit <= 16'h0000;
        end else if (out_valid && out_ready && out_y && (r_hit != 16'hFFFF)) begin
            r_hit <= r_hit + 16'h0001;
        end
    end

    assign hit_count = r_hit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reduce_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_reduce_tree_pipe
// Summary  : Directed self-checking bench for reduce_tree_pipe (WIDTH 27 and 25).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reduce_tree_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mode = 2'b00;
    logic [26:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_y;
    logic [1:0]  out_mode;

    logic        v25 = 1'b0;
    logic        rdy25;
    logic [1:0]  mode25 = 2'b00;
    logic [24:0] data25 = '0;
    logic        ov25;
    logic        ordy25 = 1'b1;
    logic        y25;
    logic [1:0]  om25;

`ifdef REDUCE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] hit25;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reduce_tree_pipe #(.WIDTH(27)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_mode  (out_mode)
`ifdef REDUCE_STATS_EN
        ,
        .hit_count (hit_count)
`endif
    );

    reduce_tree_pipe #(.WIDTH(25)) u_dut25 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v25),
        .in_ready  (rdy25),
        .in_mode   (mode25),
        .in_data   (data25),
        .out_valid (ov25),
        .out_ready (ordy25),
        .out_y     (y25),
        .out_mode  (om25)
`ifdef REDUCE_STATS_EN
        ,
        .hit_count (hit25)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word to the 27-bit DUT for a single accepted cycle.
    task automatic send27(input logic [1:0] m, input logic [26:0] d);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        step();
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_y",     {15'd0, out_y},     16'd0);
        check("rst_out_mode",  {14'd0, out_mode},  16'd0);
        check("rst_in_ready",  {15'd0, in_ready},  16'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {15'd0, in_ready}, 16'd1);

        // OR on WIDTH=27: zero word then a single set bit
        send27(2'b00, 27'h0);
        send27(2'b00, 27'h0000400);
        in_valid = 1'b0;
        check("or_lat_not_yet", {15'd0, out_valid}, 16'd0);
        step();
        check("or_zero_valid", {15'd0, out_valid}, 16'd1);
        check("or_zero_y",     {15'd0, out_y},     16'd0);
        step();
        check("or_bit_valid", {15'd0, out_valid}, 16'd1);
        check("or_bit_y",     {15'd0, out_y},     16'd1);
        step();
        check("or_drained", {15'd0, out_valid}, 16'd0);

        // AND padding and NOR on WIDTH=25
        v25 = 1'b1; mode25 = 2'b01; data25 = 25'h1FFFFFF; step();
        mode25 = 2'b01; data25 = 25'h1FFFFFE; step();
        mode25 = 2'b11; data25 = 25'h0; step();
        v25 = 1'b0;
        check("and_ones_y",    {15'd0, y25},  16'd1);
        check("and_ones_mode", {14'd0, om25}, 16'd1);
        step();
        check("and_hole_y",    {15'd0, y25},  16'd0);
        step();
        check("nor_zero_y",    {15'd0, y25},  16'd1);
        check("nor_zero_mode", {14'd0, om25}, 16'd3);
        step();
        check("w25_drained", {15'd0, ov25}, 16'd0);

        // XOR streaming
        send27(2'b10, 27'h1);
        send27(2'b10, 27'h3);
        send27(2'b10, 27'h7);
        in_valid = 1'b0;
        check("xor0_y", {15'd0, out_y}, 16'd1);
        check("xor0_m", {14'd0, out_mode}, 16'd2);
        step();
        check("xor1_v", {15'd0, out_valid}, 16'd1);
        check("xor1_y", {15'd0, out_y}, 16'd0);
        check("xor1_m", {14'd0, out_mode}, 16'd2);
        step();
        check("xor2_y", {15'd0, out_y}, 16'd1);
        check("xor2_m", {14'd0, out_mode}, 16'd2);
        step();

        // Backpressure: three accepted, then stall, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'b00; in_data = 27'h1; #1;
        check("bp_rdy0", {15'd0, in_ready}, 16'd1);
        step();
        in_mode = 2'b01; in_data = 27'h0; #1;
        check("bp_rdy1", {15'd0, in_ready}, 16'd1);
        step();
        in_mode = 2'b10; in_data = 27'h3; #1;
        check("bp_rdy2", {15'd0, in_ready}, 16'd1);
        step();
        in_mode = 2'b11; in_data = 27'h0; #1;
        check("bp_full", {15'd0, in_ready}, 16'd0);
        step();
        check("bp_full_hold", {15'd0, in_ready}, 16'd0);
        check("bp_hold_y",    {15'd0, out_y},    16'd1);
        check("bp_hold_m",    {14'd0, out_mode}, 16'd0);
        out_ready = 1'b1; #1;
        check("bp_release_rdy", {15'd0, in_ready}, 16'd1);
        step();
        check("bp_o1_y", {15'd0, out_y}, 16'd0);
        check("bp_o1_m", {14'd0, out_mode}, 16'd1);
        in_mode = 2'b00; in_data = 27'h0; #1;
        check("bp_rdy4", {15'd0, in_ready}, 16'd1);
        step();
        in_valid = 1'b0;
        check("bp_o2_y", {15'd0, out_y}, 16'd0);
        check("bp_o2_m", {14'd0, out_mode}, 16'd2);
        step();
        check("bp_o3_y", {15'd0, out_y}, 16'd1);
        check("bp_o3_m", {14'd0, out_mode}, 16'd3);
        step();
        check("bp_o4_v", {15'd0, out_valid}, 16'd1);
        check("bp_o4_y", {15'd0, out_y}, 16'd0);
        check("bp_o4_m", {14'd0, out_mode}, 16'd0);
        step();
        check("bp_empty", {15'd0, out_valid}, 16'd0);

        // Reset with two words in flight
        send27(2'b11, 27'h0);
        send27(2'b11, 27'h0);
        in_valid = 1'b0;
        rst = 1'b1; #1;
        check("rst_mid_rdy", {15'd0, in_ready}, 16'd0);
        step();
        rst = 1'b0;
        check("rst_mid_v", {15'd0, out_valid}, 16'd0);
        check("rst_mid_m", {14'd0, out_mode}, 16'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_mid_quiet", {15'd0, out_valid}, 16'd0);
        end

`ifdef REDUCE_STATS_EN
        check("hit_after_rst", hit_count, 16'h0000);
        in_valid = 1'b1; in_mode = 2'b00; in_data = 27'h1;
        for (int i = 0; i < 65537; i++) begin
            step();
        end
        in_valid = 1'b0;
        step(); step(); step(); step();
        check("hit_saturated", hit_count, 16'hFFFF);
        send27(2'b00, 27'h0);
        in_valid = 1'b0;
        step(); step(); step();
        check("hit_zero_result", hit_count, 16'hFFFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("hit_cleared", hit_count, 16'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
